// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I control state machine
//
// Sequences the shared datapath (one memory port, one ALU, IR, PC) over
// several cycles per instruction, using the latched opcode and ALU Zero.
// ALUOp and ImmSrc use the single-cycle encodings, so the ALU decoder
// attaches unchanged.
//
// Optional feature: MCTRL_MEM_WAIT_EN - when defined, FETCH, MEMREAD and
// MEMWRITE stall until mem_ready; when undefined, mem_ready is ignored.
//
// Ports:
//   clk        in  1  core clock, rising edge
//   reset_n    in  1  synchronous active-low reset
//   op         in  7  opcode field of the instruction register
//   Zero       in  1  ALU zero flag
//   mem_ready  in  1  memory access complete (wait-state build only)
//   PCWrite    out 1  PC enable
//   AdrSrc     out 1  memory address select (0 PC, 1 Result)
//   MemWrite   out 1  memory write enable
//   IRWrite    out 1  IR / OldPC enable
//   ResultSrc  out 2  00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA    out 2  00 PC, 01 OldPC, 10 register A
//   ALUSrcB    out 2  00 WriteData, 01 ImmExt, 10 constant 4
//   ALUOp      out 2  00 add, 01 subtract, 10 funct-decoded
//   RegWrite   out 1  register file write enable
//   ImmSrc     out 2  immediate format
//   Illegal    out 1  unsupported opcode trapped
//   state      out 4  current state (debug)

module multicycle_ctrl (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] op,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       RegWrite,
   output logic [1:0] ImmSrc,
   output logic       Illegal,
   output logic [3:0] state
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   state_t state_q, state_d;
   state_t out_state;
   logic   ready;
   logic   pc_update;
   logic   branch;
   logic   reg_write_raw;
   logic   mem_write_raw;
   logic   ir_write_raw;

`ifdef MCTRL_MEM_WAIT_EN
   assign ready = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign ready = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_JAL:       state_d = S_JAL;
               OP_BEQ:       state_d = S_BEQ;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = ready ? S_FETCH : S_MEMWRITE;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_BEQ:      state_d = S_FETCH;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_FETCH;
      endcase
   end

   // While reset is held the outputs decode as FETCH regardless of the
   // register contents, and all write enables are masked below, so a
   // stuck TRAP or half-done instruction cannot disturb the datapath.
   assign out_state = reset_n ? state_q : S_FETCH;

   always_comb begin
      pc_update     = 1'b0;
      branch        = 1'b0;
      ir_write_raw  = 1'b0;
      mem_write_raw = 1'b0;
      reg_write_raw = 1'b0;
      AdrSrc        = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      ALUOp         = 2'b00;
      Illegal       = 1'b0;
      case (out_state)
         S_FETCH: begin
            // IR and PC strobe only in the cycle the read completes.
            ir_write_raw = ready;
            pc_update    = ready;
            ALUSrcB      = 2'b10;
            ResultSrc    = 2'b10;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc     = 2'b01;
            reg_write_raw = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc        = 1'b1;
            mem_write_raw = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
         end
         S_ALUWB: begin
            reg_write_raw = 1'b1;
         end
         S_JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            branch  = 1'b1;
         end
         S_TRAP: begin
            Illegal = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign PCWrite  = reset_n & (pc_update | (branch & Zero));
   assign IRWrite  = reset_n & ir_write_raw;
   assign MemWrite = reset_n & mem_write_raw;
   assign RegWrite = reset_n & reg_write_raw;
   assign state    = state_q;

   always_comb begin
      ImmSrc = 2'b00;
      case (op)
         OP_LW, OP_I: ImmSrc = 2'b00;
         OP_SW:       ImmSrc = 2'b01;
         OP_BEQ:      ImmSrc = 2'b10;
         OP_JAL:      ImmSrc = 2'b11;
         default:     ImmSrc = 2'b00;
      endcase
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control state machine for the multicycle RV32I core. It sequences the shared datapath (single memory port, single ALU, instruction register, PC) across several cycles per instruction, driven by the opcode of the latched instruction and the ALU `Zero` flag. It sits beside the datapath in place of the single-cycle main decoder. It reuses the same `ALUOp` and `ImmSrc` encodings, so the existing ALU decoder connects unchanged.

## Interface
- No parameters.
- `clk` — input, 1 — core clock; all state changes on rising edge.
- `reset_n` — input, 1 — synchronous, active-low reset.
- `op` — input, 7 — opcode field of the instruction register (`instr[6:0]`).
- `Zero` — input, 1 — ALU zero flag, same cycle.
- `mem_ready` — input, 1 — memory access complete; used only when `MCTRL_MEM_WAIT_EN` is defined.
- `PCWrite` — output, 1 — PC register enable.
- `AdrSrc` — output, 1 — memory address select: 0 = PC, 1 = Result.
- `MemWrite` — output, 1 — memory write enable.
- `IRWrite` — output, 1 — instruction register and OldPC enable.
- `ResultSrc` — output, 2 — Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` — output, 2 — ALU A select: 00 = PC, 01 = OldPC, 10 = register A.
- `ALUSrcB` — output, 2 — ALU B select: 00 = register WriteData, 01 = ImmExt, 10 = constant 4.
- `ALUOp` — output, 2 — 00 = add, 01 = subtract, 10 = funct-decoded.
- `RegWrite` — output, 1 — register file write enable.
- `ImmSrc` — output, 2 — immediate format.
- `Illegal` — output, 1 — unsupported opcode trapped.
- `state` — output, 4 — current state encoding, for debug only.

## Operation
- **States and encodings:** FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, JAL=9, BEQ=10, TRAP=11. Encodings 12–15 go to FETCH.
- **Moore outputs per state** (unlisted signals are 0; `ALUSrcA`/`ALUSrcB`/`ResultSrc`/`ALUOp` default to 00):
  - FETCH: `IRWrite`=1, `ALUSrcB`=10, `ResultSrc`=10, PCUpdate=1. Next: DECODE.
  - DECODE: `ALUSrcA`=01, `ALUSrcB`=01. This computes the branch/jal target into ALUOut.
  - MEMADR: `ALUSrcA`=10, `ALUSrcB`=01.
  - MEMREAD: `AdrSrc`=1. Next: MEMWB.
  - MEMWB: `ResultSrc`=01, `RegWrite`=1. Next: FETCH.
  - MEMWRITE: `AdrSrc`=1, `MemWrite`=1. Next: FETCH.
  - EXECR: `ALUSrcA`=10, `ALUOp`=10. Next: ALUWB.
  - EXECI: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10. Next: ALUWB.
  - ALUWB: `RegWrite`=1. Next: FETCH.
  - JAL: `ALUSrcA`=01, `ALUSrcB`=10, PCUpdate=1. Next: ALUWB.
  - BEQ: `ALUSrcA`=10, `ALUOp`=01, Branch=1. Next: FETCH.
  - TRAP: `Illegal`=1. Next: TRAP; only reset exits.
- **DECODE transitions by `op`:**
  - 0000011 (lw) or 0100011 (sw) → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1101111 → JAL.
  - 1100011 → BEQ.
  - any other value → TRAP.
- **MEMADR transitions:** `op`=0000011 → MEMREAD; otherwise → MEMWRITE.
- **PC write:** `PCWrite` = PCUpdate | (Branch & `Zero`).
- **`ImmSrc`:** combinational from `op`, independent of state.
  - 0000011 or 0010011 → 00.
  - 0100011 → 01.
  - 1100011 → 10.
  - 1101111 → 11.
  - other → 00.
- **`op` sampling:** `op` is read only in DECODE and MEMADR. The IR is stable then, because `IRWrite` is asserted only in FETCH.

## Timing
- **Reset:** while `reset_n`=0 at a rising edge, the state becomes FETCH.
- **Outputs during reset:** while `reset_n` is low, `PCWrite`, `IRWrite`, `MemWrite` and `RegWrite` are forced to 0, so no architectural state changes. Mux selects show FETCH values, and `Illegal`=0.
- **First fetch:** the first edge after `reset_n` rises performs the fetch.
- **Reset mid-instruction:** aborts the instruction and returns to FETCH next edge. A register or memory write already committed is not undone.
- **Cycles per instruction** (FETCH to next FETCH, no wait states):
  - lw: 5.
  - sw, R-type, I-type, jal: 4.
  - beq: 3.
- **Branch resolution:** the branch decision uses `Zero` in the BEQ cycle only.
- **Exit from TRAP:** reset only.

## Configuration
- **`MCTRL_MEM_WAIT_EN` defined:**
  - FETCH, MEMREAD and MEMWRITE hold their state while `mem_ready`=0. Mux outputs stay steady and `MemWrite` stays asserted in MEMWRITE.
  - `IRWrite` and PCUpdate are qualified by `mem_ready`, so they strobe only in the completing cycle.
  - The state advances on the edge where `mem_ready`=1.
- **`MCTRL_MEM_WAIT_EN` undefined:**
  - `mem_ready` is ignored and every state lasts exactly one cycle.
  - Output behaviour is identical to the defined case with `mem_ready` tied to 1.

## Test plan
- **Reset:** hold `reset_n`=0 for 3 cycles with `op`=0110011 → `state`=0 and all four write enables 0. Release → the first edge has `IRWrite`=1 and `PCWrite`=1.
- **Load sequence:** `op`=0000011 → states 0,1,2,3,4,0. `RegWrite`=1 only in state 4 with `ResultSrc`=01. `ImmSrc`=00.
- **Branch:** `op`=1100011 → states 0,1,10,0.
  - `Zero`=1 gives `PCWrite`=1 in BEQ, `ALUOp`=01, `ImmSrc`=10.
  - Repeat with `Zero`=0 → `PCWrite`=0.
- **Jump:** `op`=1101111 → states 0,1,9,8,0. `PCWrite`=1 in JAL, `RegWrite`=1 in ALUWB, `ImmSrc`=11.
- **Illegal opcode:** `op`=0110111 → DECODE goes to state 11 with `Illegal`=1, held for 10 cycles. Then `reset_n`=0 for 1 cycle → `state`=0.
- **Wait states (`MCTRL_MEM_WAIT_EN` defined):** `op`=0100011 with `mem_ready`=0 for 3 cycles in MEMWRITE → `MemWrite` stays 1 for 4 cycles, then FETCH. Also, `mem_ready` low in FETCH keeps `IRWrite`=0 until the ready cycle.
